code_entry_ctrl: RTL and testbench

Central controller for the numeric code detonator. It consumes single-cycle pulses from the four key debouncers and sequences code entry on 4 BCD digits. It checks the entry against a preset code and arms a countdown that either is disarmed by a second correct entry or runs out and asserts detonate. After MAX_ERR wrong entries it locks the keypad for a timed period.

---
 rtl/code_entry_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_code_entry_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_ctrl.sv
// rtl/code_entry_ctrl.sv - code entry, arm/disarm countdown and lockout controller
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   key_inc/next/ok/clr            single-cycle debounced key pulses
//   code[15:0]                     preset code, 4 BCD digits, [15:12] = position 0
//   digits[15:0], cur_pos[1:0]     current entry and edited position
//   armed, locked, detonate        state flags
//   countdown[7:0], err_cnt[1:0]   seconds remaining, consecutive wrong entries
//   ok_pulse, err_pulse            one-cycle result pulses after key_ok
module code_entry_ctrl #(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int COUNT_INIT  = 10,
   parameter int MAX_ERR     = 3,
   parameter int LOCK_SEC    = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_inc,
   input  logic        key_next,
   input  logic        key_ok,
   input  logic        key_clr,
   input  logic [15:0] code,
   output logic [15:0] digits,
   output logic [1:0]  cur_pos,
   output logic        armed,
   output logic        locked,
   output logic        detonate,
   output logic [7:0]  countdown,
   output logic [1:0]  err_cnt,
   output logic        ok_pulse,
   output logic        err_pulse
);

   typedef enum logic [1:0] {S_ENTRY, S_ARMED, S_LOCKED, S_BOOM} state_t;

   localparam int              CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [7:0]      CD_INIT   = 8'(COUNT_INIT);
   localparam logic [7:0]      LOCK_INIT = 8'(LOCK_SEC);
   localparam logic [2:0]      ERR_LIM   = 3'(MAX_ERR);

   state_t        state, state_nxt;
   logic [15:0]   digits_nxt, digits_inc;
   logic [1:0]    pos_nxt;
   logic [7:0]    cd_nxt;
   logic [1:0]    err_nxt;
   logic [CW-1:0] tick_cnt, tcnt_nxt;
   logic          okp_nxt, errp_nxt;
   logic          timed, tick, match;
   logic          act_clr, act_ok, act_next, act_inc;

   // Priority clr > ok > next > inc: exactly one key action per cycle.
   assign act_clr  = key_clr;
   assign act_ok   = key_ok  & ~key_clr;
   assign act_next = key_next & ~key_ok & ~key_clr;
   assign act_inc  = key_inc & ~key_next & ~key_ok & ~key_clr;

   assign match = (digits == code);
   assign timed = (state == S_ARMED) || (state == S_LOCKED);
   assign tick  = timed && (tick_cnt == TICK_LAST);

   // State register (also holds the datapath registers)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_ENTRY;
         digits    <= '0;
         cur_pos   <= '0;
         countdown <= '0;
         err_cnt   <= '0;
         tick_cnt  <= '0;
         ok_pulse  <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         digits    <= digits_nxt;
         cur_pos   <= pos_nxt;
         countdown <= cd_nxt;
         err_cnt   <= err_nxt;
         tick_cnt  <= tcnt_nxt;
         ok_pulse  <= okp_nxt;
         err_pulse <= errp_nxt;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_nxt  = state;
      digits_nxt = digits;
      pos_nxt    = cur_pos;
      cd_nxt     = countdown;
      err_nxt    = err_cnt;
      okp_nxt    = 1'b0;
      errp_nxt   = 1'b0;
      tcnt_nxt   = timed ? (tick ? '0 : tick_cnt + CNT_ONE) : '0;

      // BCD increment of the digit under cur_pos, 9 wraps to 0
      digits_inc = digits;
      for (int i = 0; i < 4; i++) begin
         if (cur_pos == 2'(i)) begin
            digits_inc[(3-i)*4 +: 4] = (digits[(3-i)*4 +: 4] == 4'd9) ? 4'd0
                                     : digits[(3-i)*4 +: 4] + 4'd1;
         end
      end

      case (state)
         S_ENTRY, S_ARMED: begin
            if (act_clr || act_ok) begin
               digits_nxt = '0;
               pos_nxt    = '0;
            end else if (act_next) begin
               pos_nxt = cur_pos + 2'd1;
            end else if (act_inc) begin
               digits_nxt = digits_inc;
            end

            if (state == S_ENTRY) begin
               if (act_ok && match) begin
                  state_nxt = S_ARMED;
                  cd_nxt    = CD_INIT;
                  err_nxt   = '0;
                  okp_nxt   = 1'b1;
               end else if (act_ok) begin
                  errp_nxt = 1'b1;
                  if ({1'b0, err_cnt} + 3'd1 == ERR_LIM) begin
                     state_nxt = S_LOCKED;
                     cd_nxt    = LOCK_INIT;
                     err_nxt   = ERR_LIM[1:0];
                  end else begin
                     err_nxt = err_cnt + 2'd1;
                  end
               end
            end else begin
               // A correct disarm beats the final tick.
               if (act_ok && match) begin
                  state_nxt = S_ENTRY;
                  cd_nxt    = '0;
                  okp_nxt   = 1'b1;
               end else begin
                  errp_nxt = act_ok;
                  if (tick) begin
                     if (countdown == 8'd1) begin
                        state_nxt = S_BOOM;
                        cd_nxt    = '0;
                     end else begin
                        cd_nxt = countdown - 8'd1;
                     end
                  end
               end
            end
         end
         S_LOCKED: begin
            digits_nxt = '0;
            pos_nxt    = '0;
            if (tick) begin
               if (countdown == 8'd1) begin
                  state_nxt = S_ENTRY;
                  cd_nxt    = '0;
                  err_nxt   = '0;
               end else begin
                  cd_nxt = countdown - 8'd1;
               end
            end
         end
         default: ;
      endcase

      // Each timed period starts from a fresh tick count.
      if (state_nxt != state) tcnt_nxt = '0;
   end

   // Output decode from the registered state
   always_comb begin
      armed    = 1'b0;
      locked   = 1'b0;
      detonate = 1'b0;
      case (state)
         S_ARMED:  armed    = 1'b1;
         S_LOCKED: locked   = 1'b1;
         S_BOOM:   detonate = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb/tb_code_entry_ctrl.sv - directed self-checking bench for code_entry_ctrl
module tb_code_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_inc, key_next, key_ok, key_clr;
   logic [15:0] code;
   logic [15:0] digits;
   logic [1:0]  cur_pos;
   logic        armed, locked, detonate;
   logic [7:0]  countdown;
   logic [1:0]  err_cnt;
   logic        ok_pulse, err_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   code_entry_ctrl #(
      .TICK_CYCLES (10),
      .COUNT_INIT  (3),
      .MAX_ERR     (3),
      .LOCK_SEC    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_inc   (key_inc),
      .key_next  (key_next),
      .key_ok    (key_ok),
      .key_clr   (key_clr),
      .code      (code),
      .digits    (digits),
      .cur_pos   (cur_pos),
      .armed     (armed),
      .locked    (locked),
      .detonate  (detonate),
      .countdown (countdown),
      .err_cnt   (err_cnt),
      .ok_pulse  (ok_pulse),
      .err_pulse (err_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic i, input logic n, input logic o, input logic c);
      key_inc  = i;
      key_next = n;
      key_ok   = o;
      key_clr  = c;
      @(posedge clk);
      #1;
      key_inc  = 1'b0;
      key_next = 1'b0;
      key_ok   = 1'b0;
      key_clr  = 1'b0;
   endtask

   // Keys in digit order, one next after each digit (14 presses for 1234).
   task automatic enter_code(input logic [15:0] c);
      logic [3:0] nib;
      for (int p = 0; p < 4; p++) begin
         nib = c[(3-p)*4 +: 4];
         repeat (int'(nib)) press(1, 0, 0, 0);
         press(0, 1, 0, 0);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      rst_n    = 1'b0;
      key_inc  = 1'b0;
      key_next = 1'b0;
      key_ok   = 1'b0;
      key_clr  = 1'b0;
      code     = 16'h1234;
      step(3);
      rst_n = 1'b1;
      step(1);

      // Reset state
      check("rst_digits", digits, 16'h0000);
      check("rst_pos", cur_pos, 2'd0);
      check("rst_flags", {armed, locked, detonate}, 3'b000);
      check("rst_cd", countdown, 8'd0);
      check("rst_err", err_cnt, 2'd0);
      check("rst_pulses", {ok_pulse, err_pulse}, 2'b00);

      // 1. Editing
      repeat (12) press(1, 0, 0, 0);
      check("inc12", digits, 16'h2000);
      press(0, 1, 0, 0);
      repeat (3) press(1, 0, 0, 0);
      check("inc_pos1", digits, 16'h2300);
      check("pos1", cur_pos, 2'd1);
      repeat (3) press(0, 1, 0, 0);
      check("pos_wrap", cur_pos, 2'd0);
      press(0, 0, 0, 1);
      check("clr_digits", digits, 16'h0000);
      check("clr_pos", cur_pos, 2'd0);

      // 2. Arm then disarm
      enter_code(16'h1234);
      check("entered", digits, 16'h1234);
      press(0, 0, 1, 0);
      check("arm_okp", ok_pulse, 1'b1);
      check("arm_armed", armed, 1'b1);
      check("arm_cd", countdown, 8'd3);
      check("arm_digits", digits, 16'h0000);
      step(1);
      check("arm_okp_1cyc", ok_pulse, 1'b0);
      step(8);
      check("cd_before_tick", countdown, 8'd3);
      step(1);
      check("cd_after_tick", countdown, 8'd2);
      press(0, 0, 0, 1);
      enter_code(16'h1234);
      press(0, 0, 1, 0);
      check("disarm_armed", armed, 1'b0);
      check("disarm_cd", countdown, 8'd0);
      check("disarm_okp", ok_pulse, 1'b1);

      // 3. Detonation
      enter_code(16'h1234);
      press(0, 0, 1, 0);
      step(10);
      check("det_cd2", countdown, 8'd2);
      step(10);
      check("det_cd1", countdown, 8'd1);
      step(9);
      check("det_pre", {armed, detonate}, 2'b10);
      step(1);
      check("det_boom", {armed, detonate}, 2'b01);
      check("det_cd0", countdown, 8'd0);
      enter_code(16'h1234);
      press(0, 0, 1, 0);
      check("boom_digits", digits, 16'h0000);
      check("boom_pulse", {ok_pulse, err_pulse}, 2'b00);
      check("boom_hold", detonate, 1'b1);
      pulse_reset();
      check("boom_rst", detonate, 1'b0);

      // 4. Lockout
      press(0, 0, 1, 0);
      check("err1", {err_pulse, err_cnt, locked}, {1'b1, 2'd1, 1'b0});
      press(0, 0, 1, 0);
      check("err2", {err_pulse, err_cnt, locked}, {1'b1, 2'd2, 1'b0});
      press(0, 0, 1, 0);
      check("err3", {err_pulse, err_cnt, locked}, {1'b1, 2'd3, 1'b1});
      check("lock_cd", countdown, 8'd2);
      press(1, 0, 0, 0);
      check("lock_inc_ignored", digits, 16'h0000);
      check("lock_errp_1cyc", err_pulse, 1'b0);
      step(18);
      check("lock_pre", {locked, countdown}, {1'b1, 8'd1});
      step(1);
      check("lock_end", {locked, err_cnt, countdown}, {1'b0, 2'd0, 8'd0});

      // 5. Simultaneous keys and disarm on the final tick
      press(1, 1, 0, 0);
      check("incnext_pos", cur_pos, 2'd1);
      check("incnext_digits", digits, 16'h0000);
      press(1, 0, 0, 1);
      check("clrinc_pos", cur_pos, 2'd0);
      enter_code(16'h1234);
      press(0, 0, 1, 0);
      press(0, 0, 1, 0);
      check("armed_wrong", {armed, err_pulse, err_cnt}, {1'b1, 1'b1, 2'd0});
      enter_code(16'h1234);
      step(14);
      check("last_tick_pre", countdown, 8'd1);
      press(0, 0, 1, 0);
      check("last_tick_ok", {armed, detonate, ok_pulse}, 3'b001);
      check("last_tick_cd", countdown, 8'd0);
      step(1);
      check("last_tick_after", detonate, 1'b0);

      // 6. Asynchronous reset while armed
      enter_code(16'h1234);
      press(0, 0, 1, 0);
      step(10);
      press(1, 0, 0, 0);
      check("pre_rst", {armed, countdown, digits}, {1'b1, 8'd2, 16'h1000});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_flags", {armed, locked, detonate}, 3'b000);
      check("async_cd", countdown, 8'd0);
      check("async_digits", digits, 16'h0000);
      check("async_misc", {cur_pos, err_cnt, ok_pulse, err_pulse}, 6'd0);
      #2;
      rst_n = 1'b1;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
